sync_fifo_ctr_param: RTL and testbench
======================================

Name: sync_fifo_ctr_param

Overview:
Single-clock, parametrised FIFO controller with integrated storage. It is the next generation of the team's FIFO control block. It adds generic width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode. It sits between same-clock producer and consumer stages where no clock-domain crossing is needed.

Parameters:
DATA_WIDTH, 32, width of w_data/r_data in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16), ADDR_WIDTH >= 2
AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
w_valid  input  1  write request
w_data  input  DATA_WIDTH  write data
r_valid  input  1  read request (pop)
r_data  output  DATA_WIDTH  read data
r_ack  output  1  r_data holds valid popped/head data
full  output  1  DEPTH entries stored
empty  output  1  0 entries stored
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, r_data=0, r_ack=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. Storage array is not reset. Reset mid-operation discards all contents immediately.
- Pointers are ADDR_WIDTH+1 bits, binary, and wrap naturally; the storage index is the low ADDR_WIDTH bits.
- full = (MSBs differ) and (low bits equal). empty = pointers identical. All flags derive from registered pointers/count and change in the cycle after the accepting edge.
- Write accepted iff w_valid && !full. Read accepted iff r_valid && !empty. Both use the flags of the current cycle.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- Full with both requests: the read is accepted, the write is rejected, and overflow is set.
- Empty with both requests: the write is accepted, the read is rejected, and underflow is set.
- count: +1 on write only, -1 on read only, unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- overflow/underflow: set on a rejected request and held until clr_err=1. If a set and a clear occur in the same cycle, the set wins.
- FWFT=0: on an accepted read, r_data <= mem[rd_ptr] and r_ack=1 in the next cycle (1-cycle latency). Otherwise r_ack=0 and r_data holds its last value.
- FWFT=1: r_data = mem[rd_ptr] (combinational from registered state) and r_ack = !empty. An accepted read pops the head; the next entry appears in the following cycle. A write into an empty FIFO is visible on r_data one cycle after the write edge.
- Write-then-read of the same location in consecutive cycles returns the new data (no read-during-write hazard at the boundary).
- Threshold flags are recomputed from the registered count each cycle; equality with the threshold counts as asserted.

Test Plan:
1. Reset, then 16 writes of 0x00..0x0F with no reads -> count=16, full=1, almost_full=1 from the 12th write onward; 17th write rejected, overflow=1, contents unchanged.
2. Continue from 1: 16 reads with FWFT=0 -> r_data sequence 0x00..0x0F, each with r_ack one cycle after its read; empty=1, almost_empty=1 at count<=4; 17th read sets underflow=1.
3. FWFT=1, single write of 0xA5 into an empty FIFO -> next cycle r_data=0xA5, r_ack=1, empty=0; read pops it, then empty=1 and r_ack=0.
4. Simultaneous w_valid/r_valid every cycle for 40 cycles from count=8 -> count stays 8, pointers wrap past 16 twice, data order preserved.
5. Full + simultaneous read/write -> read accepted, write dropped, overflow=1, count=15. Then clr_err=1 for 1 cycle -> overflow=0.
6. Assert rst_n low mid-burst at count=9 -> all outputs return to reset values immediately (asynchronously); after release, the first write/read round-trips correctly.

Source files
------------

// File: rtl/sync_fifo_ctr_param.sv
// Single-clock FIFO controller with integrated storage.
// Provides occupancy count, almost-full/almost-empty thresholds, sticky error
// flags and an optional first-word-fall-through read port.
module sync_fifo_ctr_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_ack,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_en;
  logic                  rd_en;

  // Status flags come only from registered pointers and count.
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign wr_en = w_valid && !full;
  assign rd_en = r_valid && !empty;

  // Storage write; the array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= w_data;
  end

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy tracks the net of accepted writes and reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_en && !rd_en) begin
      count <= count + PTR_ONE;
    end else if (rd_en && !wr_en) begin
      count <= count - PTR_ONE;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_valid && full)  || (overflow  && !clr_err);
      underflow <= (r_valid && empty) || (underflow && !clr_err);
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      // Registered read: popped word appears one cycle after the read edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
          r_ack  <= 1'b0;
        end else begin
          r_ack <= rd_en;
          if (rd_en) r_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end
    end else begin : g_fwft_read
      // Head word is presented directly; forced to zero while empty so the
      // port shows a defined value out of reset.
      assign r_data = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
      assign r_ack  = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctr_param.sv
// Bench: one standard-read and one FWFT instance share the same stimulus and
// are checked against a queue-based model every cycle, plus directed checks.
module tb_sync_fifo_ctr_param;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_valid = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          r_valid = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] r_data0, r_data1;
  logic          r_ack0, r_ack1, full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1, ovf0, ovf1, udf0, udf1;
  logic [AW:0]   count0, count1;

  sync_fifo_ctr_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(12),
                        .AEMPTY_TH(4), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data),
    .r_valid(r_valid), .r_data(r_data0), .r_ack(r_ack0), .full(full0),
    .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .clr_err(clr_err));

  sync_fifo_ctr_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(12),
                        .AEMPTY_TH(4), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_data(w_data),
    .r_valid(r_valid), .r_data(r_data1), .r_ack(r_ack1), .full(full1),
    .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .clr_err(clr_err));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of stored words plus sticky bits.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_rack0;
  logic [DW-1:0] m_rdata0;
  bit            m_wacc, m_racc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rack0 = 0; m_rdata0 = '0;
    end else begin
      m_wacc = w_valid && (q.size() < DEPTH);
      m_racc = r_valid && (q.size() > 0);
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
      if (w_valid && q.size() == DEPTH) m_ovf = 1;
      if (r_valid && q.size() == 0) m_udf = 1;
      if (m_racc) begin m_rdata0 = q.pop_front(); m_rack0 = 1; end
      else m_rack0 = 0;
      if (m_wacc) q.push_back(w_data);
    end
  end

  // Every-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("count0", count0, q.size());
      chk("count1", count1, q.size());
      chk("full0", full0, q.size() == DEPTH);
      chk("full1", full1, q.size() == DEPTH);
      chk("empty0", empty0, q.size() == 0);
      chk("empty1", empty1, q.size() == 0);
      chk("afull0", af0, q.size() >= 12);
      chk("afull1", af1, q.size() >= 12);
      chk("aempty0", ae0, q.size() <= 4);
      chk("aempty1", ae1, q.size() <= 4);
      chk("ovf0", ovf0, m_ovf);
      chk("ovf1", ovf1, m_ovf);
      chk("udf0", udf0, m_udf);
      chk("udf1", udf1, m_udf);
      chk("rack0", r_ack0, m_rack0);
      chk("rdata0", r_data0, m_rdata0);
      chk("rack1", r_ack1, q.size() != 0);
      if (q.size() != 0) chk("rdata1_head", r_data1, q[0]);
    end
  end

  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rv,
                      input bit clr);
    w_valid = wv; w_data = wd; r_valid = rv; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count0"}, count0, 0);
    chk({tag, "_count1"}, count1, 0);
    chk({tag, "_rdata0"}, r_data0, 0);
    chk({tag, "_rdata1"}, r_data1, 0);
    chk({tag, "_rack0"}, r_ack0, 0);
    chk({tag, "_rack1"}, r_ack1, 0);
    chk({tag, "_full"}, {full0, full1}, 2'b00);
    chk({tag, "_empty"}, {empty0, empty1}, 2'b11);
    chk({tag, "_afull"}, {af0, af1}, 2'b00);
    chk({tag, "_aempty"}, {ae0, ae1}, 2'b11);
    chk({tag, "_ovf"}, {ovf0, ovf1}, 2'b00);
    chk({tag, "_udf"}, {udf0, udf1}, 2'b00);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: fill to full, then one rejected write
    for (int i = 0; i < 16; i++) begin
      step(1, DW'(i), 0, 0);
      chk("t1_afull", af0, (i + 1) >= 12);
    end
    chk("t1_count", count0, 16);
    chk("t1_full", full0, 1);
    step(1, 32'hDEAD_BEEF, 0, 0);
    chk("t1_ovf", ovf0, 1);
    chk("t1_count_held", count0, 16);

    // 2: drain with registered reads
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 0);
      chk("t2_rack", r_ack0, 1);
      chk("t2_rdata", r_data0, DW'(i));
      chk("t2_aempty", ae0, (15 - i) <= 4);
    end
    chk("t2_empty", empty0, 1);
    step(0, '0, 1, 0);
    chk("t2_udf", udf0, 1);
    chk("t2_rack_none", r_ack0, 0);
    step(0, '0, 0, 1);
    chk("t2_clr", {ovf0, udf0}, 2'b00);

    // 3: FWFT single word
    step(1, 32'hA5, 0, 0);
    chk("t3_rdata1", r_data1, 32'hA5);
    chk("t3_rack1", r_ack1, 1);
    chk("t3_empty1", empty1, 0);
    step(0, '0, 1, 0);
    chk("t3_empty1_after", empty1, 1);
    chk("t3_rack1_after", r_ack1, 0);

    // 4: steady state at count=8 with simultaneous traffic
    for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, $urandom, 1, 0);
      chk("t4_count", count0, 8);
    end

    // 5: full with both requests, then clear
    for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0);
    chk("t5_full", full0, 1);
    step(1, 32'h5555_AAAA, 1, 0);
    chk("t5_count", count0, 15);
    chk("t5_ovf", ovf0, 1);
    step(0, '0, 0, 1);
    chk("t5_ovf_clr", ovf0, 0);

    // 6: asynchronous reset mid-burst at count=9
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0);
    chk("t6_count9", count0, 9);
    w_valid = 1; w_data = 32'h0BAD_0BAD; r_valid = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1, 32'h1234_5678, 0, 0);
    chk("t6_fwft_rt", r_data1, 32'h1234_5678);
    step(0, '0, 1, 0);
    chk("t6_std_rt", r_data0, 32'h1234_5678);
    chk("t6_std_ack", r_ack0, 1);

    // Random traffic at several fill biases
    for (int seg = 0; seg < 4; seg++) begin
      int pw, pr;
      pw = (seg == 0) ? 80 : (seg == 1) ? 50 : (seg == 2) ? 20 : 60;
      pr = 100 - pw;
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < 3);
    end
    step(0, '0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
